// File: rtl/serial_to_parallel_conv.sv
// Serial-to-parallel stage: deserializes an MSB-first bit stream into bytes and arms
// Latency: a byte's last bit sampled at edge E appears on data_out/byte_stb after E.
// Backpressure: none; one bit is consumed every clk, outputs are held between strobes.
module serial_to_parallel_conv #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_COUNT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic {SEARCH = 1'b0, ACTIVE = 1'b1} state_t;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] b;
  logic       boundary;
  logic       is_com;
  logic [3:0] com_cnt;
  logic [3:0] com_cnt_nxt;
  logic [3:0] com_cnt_inc;
  state_t     state;
  state_t     state_nxt;

  logic [7:0] data_out_nxt;
  logic       valid_out_nxt;
  logic       byte_stb_nxt;

  // Byte being completed this cycle: the seven held bits plus the incoming one.
  assign b           = {shift, data_in};
  assign boundary    = (bit_cnt == 3'd7);
  assign is_com      = (b == COM_SYMBOL);
  assign com_cnt_inc = com_cnt + 4'd1;

  // Bit framing: the byte boundary is fixed by reset release, never realigned.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      shift   <= 7'd0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= b[6:0];
    end
  end

  // FSM state and COM run-length register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      com_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      com_cnt <= com_cnt_nxt;
    end
  end

  // Next state: count consecutive COM bytes in SEARCH; ACTIVE is sticky until reset.
  always_comb begin
    state_nxt   = state;
    com_cnt_nxt = com_cnt;
    if (boundary && state == SEARCH) begin
      if (is_com) begin
        if (com_cnt_inc == COM_TARGET) begin
          state_nxt   = ACTIVE;
          com_cnt_nxt = 4'd0;
        end else begin
          com_cnt_nxt = com_cnt_inc;
        end
      end else begin
        com_cnt_nxt = 4'd0;
      end
    end
  end

  // Output next-values: only boundaries seen while already ACTIVE are emitted, so the
  // byte that completes the arming COM run is swallowed.
  always_comb begin
    data_out_nxt  = data_out;
    valid_out_nxt = valid_out;
    byte_stb_nxt  = 1'b0;
    if (boundary && state == ACTIVE) begin
      data_out_nxt  = b;
      valid_out_nxt = !is_com;
      byte_stb_nxt  = 1'b1;
    end
  end

  // Registered outputs; active tracks the FSM on the same edge it changes.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      byte_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      data_out  <= data_out_nxt;
      valid_out <= valid_out_nxt;
      byte_stb  <= byte_stb_nxt;
      active    <= (state_nxt == ACTIVE);
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_conv.sv
// Bench for serial_to_parallel_conv: directed framing/arming scenarios plus random bytes.
// Every clk the outputs are compared with a byte-level reference model.
// Inputs change 1 time unit after posedge; outputs are sampled at that same point.
module tb_serial_to_parallel_conv;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         NCOM = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: bits gathered into the current byte, COM run length, armed flag.
  int         m_nbits;
  int         m_acc;
  int         m_run;
  bit         m_act;
  logic [7:0] m_dout;
  logic       m_vld;
  logic       m_stb;

  serial_to_parallel_conv #(.COM_SYMBOL(COM), .COM_COUNT(NCOM)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .byte_stb  (byte_stb),
    .active    (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level model: accumulate bits arithmetically, act on every eighth one.
  task automatic model_step(input logic r, input logic d);
    m_stb = 1'b0;
    if (r) begin
      m_nbits = 0; m_acc = 0; m_run = 0; m_act = 1'b0;
      m_dout = 8'h00; m_vld = 1'b0;
    end else begin
      m_acc = (m_acc * 2 + int'(d)) % 256;
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        if (m_act) begin
          m_dout = 8'(m_acc);
          m_vld  = (m_acc != int'(COM));
          m_stb  = 1'b1;
        end else if (m_acc == int'(COM)) begin
          m_run++;
          if (m_run == NCOM) begin
            m_act = 1'b1;
            m_run = 0;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  // One clk: present inputs, let the edge happen, then compare against the model.
  task automatic step(input logic r, input logic d);
    reset   = r;
    data_in = d;
    @(posedge clk);
    model_step(r, d);
    #1;
    chk("data_out",  data_out,        m_dout);
    chk("valid_out", {7'd0, valid_out}, {7'd0, m_vld});
    chk("byte_stb",  {7'd0, byte_stb},  {7'd0, m_stb});
    chk("active",    {7'd0, active},    {7'd0, m_act});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) step(1'b0, v[i]);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b1, 1'($urandom_range(1, 0)));
  endtask

  initial begin
    logic [7:0] rb;
    reset   = 1'b1;
    data_in = 1'b0;
    m_nbits = 0; m_acc = 0; m_run = 0; m_act = 1'b0;
    m_dout = 8'h00; m_vld = 1'b0; m_stb = 1'b0;

    // 1) reset with arbitrary data
    do_reset(3);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_active", {7'd0, active}, 8'h00);

    // 2) four COM then a payload byte
    for (int k = 0; k < 3; k++) send_byte(COM);
    chk("pre_arm_active", {7'd0, active}, 8'h00);
    send_byte(COM);
    chk("arm_active", {7'd0, active}, 8'h01);
    chk("arm_no_stb", {7'd0, byte_stb}, 8'h00);
    send_byte(8'h5A);
    chk("first_byte", data_out, 8'h5A);
    chk("first_valid", {7'd0, valid_out}, 8'h01);
    chk("first_stb", {7'd0, byte_stb}, 8'h01);
    step(1'b0, 1'b1);
    chk("stb_one_clk", {7'd0, byte_stb}, 8'h00);
    chk("hold_byte", data_out, 8'h5A);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0);

    // 3) interrupted COM run restarts the count
    do_reset(1);
    send_byte(COM); send_byte(COM); send_byte(COM); send_byte(8'h11);
    send_byte(COM); send_byte(COM); send_byte(COM);
    chk("restart_active", {7'd0, active}, 8'h00);
    send_byte(COM);
    chk("restart_armed", {7'd0, active}, 8'h01);

    // 4) payload including an embedded COM
    send_byte(8'h00);
    chk("pay00", data_out, 8'h00);
    chk("pay00_v", {7'd0, valid_out}, 8'h01);
    send_byte(COM);
    chk("payBC", data_out, 8'hBC);
    chk("payBC_v", {7'd0, valid_out}, 8'h00);
    chk("payBC_stb", {7'd0, byte_stb}, 8'h01);
    send_byte(8'hFF);
    chk("payFF", data_out, 8'hFF);
    chk("payFF_v", {7'd0, valid_out}, 8'h01);

    // 5) reset mid-byte while ACTIVE, then re-arm from scratch
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_active", {7'd0, active}, 8'h00);
    for (int k = 0; k < 3; k++) send_byte(COM);
    chk("rearm_wait", {7'd0, active}, 8'h00);
    send_byte(COM);
    chk("rearm_done", {7'd0, active}, 8'h01);

    // 6) random payload stream, COM-biased
    for (int k = 0; k < 200; k++) begin
      rb = ($urandom_range(3, 0) == 0) ? COM : 8'($urandom);
      send_byte(rb);
      chk("rand_byte", data_out, rb);
    end

    // random streams from reset, exercising arming with random COM runs
    for (int t = 0; t < 6; t++) begin
      do_reset(1 + $urandom_range(2, 0));
      for (int k = 0; k < 20; k++) begin
        rb = ($urandom_range(1, 0) == 0) ? COM : 8'($urandom);
        send_byte(rb);
      end
      for (int i = 0; i < int'($urandom_range(7, 0)); i++) step(1'b0, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
